// File: rtl/if_pc_unit.sv
// IF-stage fetch PC generator with redirect/stall priority and an optional
// direct-mapped branch target buffer, enabled by defining BTB_PREDICT_EN.
module if_pc_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BTB_ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_f,
   input  logic        id_redirect,
   input  logic [31:0] id_target,
   input  logic        ex_redirect,
   input  logic [31:0] ex_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken,
   output logic [31:0] pc_f,
   output logic        pred_taken_f,
   output logic [31:0] pred_target_f
);

   logic [31:0] pc_q;
   logic [31:0] pc_next;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        unused_tgt_lsb;
   logic        unused_upd;

   assign unused_tgt_lsb = ^{ex_target[1:0], id_target[1:0]};

`ifdef BTB_PREDICT_EN
   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic [BTB_ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
   logic [29:0]            tgt_q [BTB_ENTRIES];
   logic [1:0]             ctr_q [BTB_ENTRIES];
   logic [IDX_W-1:0]       rd_idx;
   logic [IDX_W-1:0]       wr_idx;
   logic                   rd_hit;
   logic                   wr_hit;

   assign rd_idx      = pc_q[2 +: IDX_W];
   assign rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == pc_q[31:2+IDX_W]);
   assign pred_taken  = rd_hit && ctr_q[rd_idx][1];
   assign pred_target = pred_taken ? {tgt_q[rd_idx], 2'b00} : 32'h0;

   assign wr_idx      = upd_pc[2 +: IDX_W];
   assign wr_hit      = valid_q[wr_idx] && (tag_q[wr_idx] == upd_pc[31:2+IDX_W]);
   assign unused_upd  = ^{upd_pc[1:0], upd_target[1:0]};

   // Only valid bits need reset; stale payload is unreachable while invalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (upd_valid && !wr_hit && upd_taken) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (upd_valid) begin
         if (wr_hit) begin
            if (upd_taken) begin
               tgt_q[wr_idx] <= upd_target[31:2];
               if (ctr_q[wr_idx] != 2'b11) begin
                  ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'd1;
               end
            end else if (ctr_q[wr_idx] != 2'b00) begin
               ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            tag_q[wr_idx] <= upd_pc[31:2+IDX_W];
            tgt_q[wr_idx] <= upd_target[31:2];
            ctr_q[wr_idx] <= 2'b10;
         end
      end
   end
`else
   localparam int unused_entries = BTB_ENTRIES;

   assign pred_taken  = 1'b0;
   assign pred_target = 32'h0;
   assign unused_upd  = ^{upd_valid, upd_pc, upd_target, upd_taken};
`endif

   // EX is older than ID, so its correction wins; any redirect beats a stall.
   always_comb begin
      pc_next = pc_q + 32'd4;
      if (ex_redirect) begin
         pc_next = {ex_target[31:2], 2'b00};
      end else if (id_redirect) begin
         pc_next = {id_target[31:2], 2'b00};
      end else if (stall_f) begin
         pc_next = pc_q;
      end else if (pred_taken) begin
         pc_next = pred_target;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_next;
      end
   end

   assign pc_f          = pc_q;
   assign pred_taken_f  = pred_taken;
   assign pred_target_f = pred_target;

endmodule

// File: tb/tb_if_pc_unit.sv
// Directed bench for if_pc_unit; BTB expectations follow BTB_PREDICT_EN.
module tb_if_pc_unit;

   logic        clk;
   logic        rst_n;
   logic        stall_f;
   logic        id_redirect;
   logic [31:0] id_target;
   logic        ex_redirect;
   logic [31:0] ex_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic [31:0] pc_f;
   logic        pred_taken_f;
   logic [31:0] pred_target_f;

   int errors = 0;
   int checks = 0;

`ifdef BTB_PREDICT_EN
   localparam bit BTB = 1'b1;
`else
   localparam bit BTB = 1'b0;
`endif

   if_pc_unit #(.RESET_PC(32'h0000_0000), .BTB_ENTRIES(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_f       (stall_f),
      .id_redirect   (id_redirect),
      .id_target     (id_target),
      .ex_redirect   (ex_redirect),
      .ex_target     (ex_target),
      .upd_valid     (upd_valid),
      .upd_pc        (upd_pc),
      .upd_target    (upd_target),
      .upd_taken     (upd_taken),
      .pc_f          (pc_f),
      .pred_taken_f  (pred_taken_f),
      .pred_target_f (pred_target_f)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic ex, input logic [31:0] ext,
                                input logic id, input logic [31:0] idt, input logic st);
      ex_redirect = ex;
      ex_target   = ext;
      id_redirect = id;
      id_target   = idt;
      stall_f     = st;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic jumpTo(input logic [31:0] addr);
      applyStimulus(1'b1, addr, 1'b0, 32'h0, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic trainBtb(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
      upd_valid  = 1'b1;
      upd_pc     = pc;
      upd_target = tgt;
      upd_taken  = taken;
      stepCycle();
      upd_valid  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      upd_valid  = 1'b0;
      upd_pc     = 32'h0;
      upd_target = 32'h0;
      upd_taken  = 1'b0;

      repeat (2) stepCycle();
      checkOutput("rst_pc", pc_f, 32'h0);
      checkOutput("rst_pred", {31'h0, pred_taken_f}, 32'h0);
      checkOutput("rst_ptgt", pred_target_f, 32'h0);
      rst_n = 1'b1;

      for (int i = 1; i <= 3; i++) begin
         stepCycle();
         checkOutput($sformatf("run_pc%0d", i), pc_f, 32'(4 * i));
         checkOutput($sformatf("run_pred%0d", i), {31'h0, pred_taken_f}, 32'h0);
      end

      jumpTo(32'h10);
      checkOutput("stall_start", pc_f, 32'h10);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         checkOutput($sformatf("stall_hold%0d", i), pc_f, 32'h10);
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      stepCycle();
      checkOutput("stall_release", pc_f, 32'h14);
      applyStimulus(1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
      stepCycle();
      checkOutput("redir_over_stall", pc_f, 32'h80);

      applyStimulus(1'b1, 32'h200, 1'b1, 32'h100, 1'b0);
      stepCycle();
      checkOutput("ex_over_id", pc_f, 32'h200);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      stepCycle();
      checkOutput("after_ex", pc_f, 32'h204);
      applyStimulus(1'b1, 32'h203, 1'b1, 32'h100, 1'b0);
      stepCycle();
      checkOutput("ex_align", pc_f, 32'h200);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h106, 1'b1);
      stepCycle();
      checkOutput("id_align", pc_f, 32'h104);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      trainBtb(32'h40, 32'h100, 1'b1);
      jumpTo(32'h40);
      checkOutput("train_pred", {31'h0, pred_taken_f}, {31'h0, BTB});
      checkOutput("train_ptgt", pred_target_f, BTB ? 32'h100 : 32'h0);
      stepCycle();
      checkOutput("train_follow", pc_f, BTB ? 32'h100 : 32'h44);

      trainBtb(32'h40, 32'h0, 1'b0);
      trainBtb(32'h40, 32'h0, 1'b0);
      jumpTo(32'h40);
      checkOutput("untrain_pred", {31'h0, pred_taken_f}, 32'h0);
      checkOutput("untrain_ptgt", pred_target_f, 32'h0);
      stepCycle();
      checkOutput("untrain_next", pc_f, 32'h44);

      trainBtb(32'h40, 32'h100, 1'b1);
      trainBtb(32'h40, 32'h100, 1'b1);
      jumpTo(32'h40);
      checkOutput("retrain_pred", {31'h0, pred_taken_f}, {31'h0, BTB});
      trainBtb(32'h80, 32'h180, 1'b1);
      jumpTo(32'h40);
      checkOutput("alias_evict", {31'h0, pred_taken_f}, 32'h0);
      jumpTo(32'h80);
      checkOutput("alias_pred", {31'h0, pred_taken_f}, {31'h0, BTB});
      checkOutput("alias_ptgt", pred_target_f, BTB ? 32'h180 : 32'h0);
      stepCycle();
      checkOutput("alias_follow", pc_f, BTB ? 32'h180 : 32'h84);

      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_pc", pc_f, 32'h0);
      stepCycle();
      rst_n = 1'b1;
      jumpTo(32'h80);
      checkOutput("rst_clears_btb", {31'h0, pred_taken_f}, 32'h0);
      stepCycle();
      checkOutput("rst_btb_next", pc_f, 32'h84);

      jumpTo(32'hFFFF_FFFC);
      checkOutput("wrap_top", pc_f, 32'hFFFF_FFFC);
      stepCycle();
      checkOutput("wrap_zero", pc_f, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_pc_unit.md
Name: if_pc_unit

Overview:
- IF-stage PC generator that sits directly upstream of the IF-ID segment register.
- Holds the fetch PC (pc_f) that addresses the instruction BRAM. The same value is also latched as PCF into the IF-ID register.
- Selects the next PC from: EX redirect, ID redirect, stall hold, a branch-target-buffer (BTB) prediction, or pc_f+4.
- The BTB is trained by resolved branches from EX.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BTB_ENTRIES, 16, number of direct-mapped BTB entries. Must be a power of two, at least 2. IDX_W = log2(BTB_ENTRIES).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_f  in  1  hold pc_f (from hazard unit).
- id_redirect  in  1  ID-stage jump (JAL) resolved.
- id_target  in  32  ID redirect target.
- ex_redirect  in  1  EX mispredict / JALR / branch correction.
- ex_target  in  32  EX corrected PC.
- upd_valid  in  1  EX branch/jump resolved this cycle; train BTB.
- upd_pc  in  32  PC of the resolved instruction.
- upd_target  in  32  its actual target.
- upd_taken  in  1  actual direction.
- pc_f  out  32  current fetch PC (BRAM address and PCF).
- pred_taken_f  out  1  BTB predicts the instruction at pc_f taken.
- pred_target_f  out  32  predicted target (0 when not predicted).

Behaviour:
- Reset (async, rst_n=0):
  - pc_f=RESET_PC.
  - All BTB valid bits = 0.
  - pred_taken_f=0 and pred_target_f=0 while in reset and until the first valid hit.
- pc_f is a register updated on each rising clk edge. Next-PC priority, highest first:
  1. ex_redirect: next = {ex_target[31:2],2'b00}.
  2. id_redirect: next = {id_target[31:2],2'b00}.
  3. stall_f: next = pc_f (hold).
  4. pred_taken_f: next = pred_target_f.
  5. Otherwise: next = pc_f+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- A redirect overrides stall_f in the same cycle.
- The simultaneous ex_redirect and id_redirect case takes EX, because the ID instruction is younger and is being flushed.
- Latency: a redirect asserted in cycle N appears on pc_f in cycle N+1.
- BTB entry layout:
  - valid (1 bit).
  - tag = pc[31:2+IDX_W].
  - target[31:2] (stored word-aligned).
  - 2-bit saturating counter ctr.
  - Index = pc[2+IDX_W-1:2].
  - Entries are flop-based, not BRAM.
- Lookup (combinational on pc_f):
  - hit = valid and tag match.
  - pred_taken_f = hit and ctr[1].
  - pred_target_f = pred_taken_f ? {target,2'b00} : 0.
- Update (on clk edge when upd_valid=1):
  - Hit on upd_pc:
    - ctr saturating +1 if upd_taken, saturating -1 otherwise (bounds 2'b00 and 2'b11).
    - If upd_taken, target is overwritten with upd_target.
  - Miss and upd_taken: allocate (replace the indexed entry). valid=1, tag and target written, ctr=2'b10.
  - Miss and not taken: no change.
- Lookup and update to the same index in the same cycle: lookup sees the pre-update contents. The write takes effect the next cycle.
- Update proceeds regardless of stall_f or redirects.
- Reset asserted mid-operation: pc_f and all valid bits clear immediately. No partial update is kept.

Optional Feature:
- Macro BTB_PREDICT_EN.
- When defined: BTB storage, lookup and update logic are implemented exactly as described above.
- When undefined:
  - No BTB storage is built.
  - pred_taken_f=0 and pred_target_f=0 constantly.
  - Next-PC priority reduces to ex_redirect > id_redirect > stall_f > pc_f+4.
  - upd_* inputs are ignored.

Test Plan:
- Reset then free-run with RESET_PC=0 and no inputs -> pc_f = 0, 4, 8, 0xC on consecutive cycles. pred_taken_f=0 throughout.
- stall_f=1 for 3 cycles at pc_f=0x10 -> pc_f holds 0x10 for 3 cycles, then 0x14. With ex_redirect=1 and ex_target=0x80 during the stall -> pc_f=0x80 next cycle.
- Same cycle: ex_redirect=1 with ex_target=0x200, and id_redirect=1 with id_target=0x100 -> pc_f=0x200. Also: ex_target=0x203 -> pc_f=0x200.
- Train a branch (BTB_PREDICT_EN defined):
  - Apply upd_valid, upd_pc=0x40, upd_target=0x100, upd_taken=1 -> when pc_f later reaches 0x40, pred_taken_f=1, pred_target_f=0x100, and the next pc_f=0x100.
  - Then apply two not-taken updates to 0x40 -> pred_taken_f=0 at 0x40 (ctr 10→01→00).
- Alias and wrap:
  - With BTB_ENTRIES=16, train 0x40 taken, then train 0x80 taken. 0x80 maps to the same index and replaces the entry, so 0x40 no longer hits (pred_taken_f=0).
  - Force pc_f=0xFFFF_FFFC via ex_redirect -> next pc_f=0x0000_0000.
- rst_n pulsed low mid-run with a trained BTB -> pc_f=RESET_PC immediately. Previously trained 0x40 no longer predicts. With BTB_PREDICT_EN undefined, the training sequence above yields pred_taken_f=0 always.
